ctl_commit_stage: RTL and testbench

- Consumer end of the stage-2 control-code interface.
- Registers the per-instruction control word (BB2, ER0, ERN, XR0, SOD, ISP, ESP, EIP, LPC, FLR0, XRN, X4SP, XWR) into a stage-3 register, advances it to stage 4, and issues the commit strobes there.
- Commit strobes: register writeback, stack-pointer update, memory/port bus request, PC load.
- Generates the stall and flush feedback that the upstream stages turn into bubbles.

---
 rtl/ctl_commit_stage.sv | 152 +++++++++++++++
 tb/tb_ctl_commit_stage.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctl_commit_stage.sv
// ---------------------------------------------------------------------------
// ctl_commit_stage
//   Consumer end of the stage-2 control-code interface. The 13-bit control
//   word is captured into S3 and advanced to S4. The commit strobes are issued
//   from S4: register writeback, stack-pointer step, memory/port bus request
//   and PC load. This block also produces the STALL and FLUSH feedback that
//   the upstream stages turn into bubbles.
//
//   Ports
//     clk, rst                     clock, synchronous active-high reset
//     BB2 .. XWR                   control word from stage 2
//     FLAG_OK                      flag-compare result, used at commit
//     MEM_ACK                      memory/port bus completion
//     WE_R0, WE_RN                 register write commit strobes
//     SP[7:0]                      stack pointer
//     MEM_REQ, MEM_WR              bus request for the S4 word, write flag
//     PC_LOAD                      taken-branch strobe
//     FWD_R0                       S3 word's FLR0 (forward select)
//     STALL                        hold stages 1-3
//     FLUSH                        words are being squashed
// ---------------------------------------------------------------------------
module ctl_commit_stage #(
    parameter logic [7:0]  SP_RESET    = 8'hFF,
    parameter int unsigned FLUSH_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BB2,
    input  logic       ER0,
    input  logic       ERN,
    input  logic       XR0,
    input  logic       SOD,
    input  logic       ISP,
    input  logic       ESP,
    input  logic       EIP,
    input  logic       LPC,
    input  logic       FLR0,
    input  logic       XRN,
    input  logic       X4SP,
    input  logic       XWR,
    input  logic       FLAG_OK,
    input  logic       MEM_ACK,
    output logic       WE_R0,
    output logic       WE_RN,
    output logic [7:0] SP,
    output logic       MEM_REQ,
    output logic       MEM_WR,
    output logic       PC_LOAD,
    output logic       FWD_R0,
    output logic       STALL,
    output logic       FLUSH
);

    typedef struct packed {
        logic bb2;
        logic er0;
        logic ern;
        logic xr0;
        logic sod;
        logic isp;
        logic esp;
        logic eip;
        logic lpc;
        logic flr0;
        logic xrn;
        logic x4sp;
        logic xwr;
    } ctl_word_t;

    localparam ctl_word_t  NOP         = '0;
    localparam logic [1:0] SQUASH_LOAD = 2'(FLUSH_DEPTH - 1);

    // Stack pointer step; 8-bit arithmetic wraps FF->00 and 00->FF.
    function automatic logic [7:0] sp_step(input logic [7:0] sp, input logic inc);
        return inc ? (sp + 8'd1) : (sp - 8'd1);
    endfunction

    ctl_word_t  word_p0;
    ctl_word_t  s3_p1;
    ctl_word_t  s4_p2;
    logic       vld_p1;
    logic       vld_p2;
    logic [7:0] sp_q;
    logic [1:0] squash_cnt;
    logic       skip_q;
    logic       mem_op_p2;
    logic       commit_p2;
    logic       s4_unused_p2;

    assign word_p0 = {BB2, ER0, ERN, XR0, SOD, ISP, ESP, EIP, LPC, FLR0, XRN, X4SP, XWR};

    // ---- S4: commit decode ----
    assign mem_op_p2 = vld_p2 & (s4_p2.xwr | s4_p2.eip);
    assign MEM_REQ   = mem_op_p2;
    assign MEM_WR    = mem_op_p2 & s4_p2.xwr;
    assign STALL     = mem_op_p2 & ~MEM_ACK;
    assign commit_p2 = vld_p2 & ~STALL;

    assign WE_R0   = commit_p2 & s4_p2.xr0;
    assign WE_RN   = commit_p2 & s4_p2.xrn;
    assign PC_LOAD = commit_p2 & s4_p2.lpc & FLAG_OK;
    assign FLUSH   = PC_LOAD | (squash_cnt != 2'd0);
    assign FWD_R0  = vld_p1 & s3_p1.flr0;
    assign SP      = sp_q;

    // Fields carried to S4 but only consumed by earlier stages.
    assign s4_unused_p2 = ^{s4_p2.bb2, s4_p2.er0, s4_p2.ern, s4_p2.sod,
                            s4_p2.esp, s4_p2.flr0};

    always_ff @(posedge clk) begin
        if (rst) begin
            s3_p1      <= NOP;
            vld_p1     <= 1'b0;
            s4_p2      <= NOP;
            vld_p2     <= 1'b0;
            sp_q       <= SP_RESET;
            squash_cnt <= 2'd0;
            skip_q     <= 1'b0;
        end else if (!STALL) begin
            // ---- S3 -> S4 ----
            s4_p2  <= s3_p1;
            vld_p2 <= vld_p1;
            if (commit_p2 && s4_p2.x4sp) begin
                sp_q <= sp_step(sp_q, s4_p2.isp);
            end

            // ---- input -> S3 ----
            // A taken branch drops the word sampled at its own commit edge,
            // then keeps dropping until the squash counter runs out.
            if (PC_LOAD) begin
                s3_p1      <= NOP;
                vld_p1     <= 1'b0;
                squash_cnt <= SQUASH_LOAD;
                skip_q     <= 1'b0;
            end else if (squash_cnt != 2'd0) begin
                s3_p1      <= NOP;
                vld_p1     <= 1'b0;
                squash_cnt <= squash_cnt - 2'd1;
            end else if (skip_q) begin
                // Operand-byte slot following a two-byte instruction.
                s3_p1  <= NOP;
                vld_p1 <= 1'b0;
                skip_q <= 1'b0;
            end else begin
                s3_p1  <= word_p0;
                vld_p1 <= |word_p0;
                skip_q <= word_p0.bb2;
            end
        end
    end

endmodule

// File: tb/tb_ctl_commit_stage.sv
module tb_ctl_commit_stage;

    localparam logic [7:0] SP_RESET    = 8'hFF;
    localparam int         FLUSH_DEPTH = 2;

    // Word layout {BB2,ER0,ERN,XR0,SOD,ISP,ESP,EIP,LPC,FLR0,XRN,X4SP,XWR}
    localparam logic [12:0] M_BB2  = 13'h1000;
    localparam logic [12:0] M_XR0  = 13'h0200;
    localparam logic [12:0] M_ISP  = 13'h0080;
    localparam logic [12:0] M_EIP  = 13'h0020;
    localparam logic [12:0] M_LPC  = 13'h0010;
    localparam logic [12:0] M_FLR0 = 13'h0008;
    localparam logic [12:0] M_XRN  = 13'h0004;
    localparam logic [12:0] M_X4SP = 13'h0002;
    localparam logic [12:0] M_XWR  = 13'h0001;

    localparam logic [12:0] W_MVI = M_XRN;
    localparam logic [12:0] W_PSH = M_X4SP | M_XWR;
    localparam logic [12:0] W_POP = M_X4SP | M_ISP | M_EIP;
    localparam logic [12:0] W_JMP = M_BB2 | M_LPC;
    localparam logic [12:0] W_CUD = M_BB2 | M_LPC | M_XWR | M_X4SP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] word = 13'h0;
    logic        flag_ok = 1'b1;
    logic        mem_ack = 1'b1;

    logic       WE_R0, WE_RN, MEM_REQ, MEM_WR, PC_LOAD, FWD_R0, STALL, FLUSH;
    logic [7:0] SP;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    ctl_commit_stage #(.SP_RESET(SP_RESET), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .BB2(word[12]), .ER0(word[11]), .ERN(word[10]), .XR0(word[9]),
        .SOD(word[8]), .ISP(word[7]), .ESP(word[6]), .EIP(word[5]),
        .LPC(word[4]), .FLR0(word[3]), .XRN(word[2]), .X4SP(word[1]),
        .XWR(word[0]),
        .FLAG_OK(flag_ok), .MEM_ACK(mem_ack),
        .WE_R0(WE_R0), .WE_RN(WE_RN), .SP(SP), .MEM_REQ(MEM_REQ),
        .MEM_WR(MEM_WR), .PC_LOAD(PC_LOAD), .FWD_R0(FWD_R0),
        .STALL(STALL), .FLUSH(FLUSH)
    );

    // Reference model: the two in-flight words as a queue (front = S3,
    // back = S4), plus counts of upcoming sampled words to drop.
    logic [12:0] pipe[$];
    logic [7:0]  m_sp;
    int          m_flush_left;
    bit          m_skip;
    bit          model_ok = 1'b0;

    always @(posedge clk) begin
        logic [12:0] s4, kept;
        bit          memop, taken;
        cyc++;
        if (rst) begin
            pipe         = '{13'h0, 13'h0};
            m_sp         = SP_RESET;
            m_flush_left = 0;
            m_skip       = 1'b0;
            model_ok     = 1'b1;
        end else if (model_ok) begin
            s4    = pipe[1];
            memop = (s4 & (M_XWR | M_EIP)) != 13'h0;
            if (!(memop && !mem_ack)) begin
                taken = ((s4 & M_LPC) != 13'h0) && flag_ok;
                if ((s4 & M_X4SP) != 13'h0)
                    m_sp = ((s4 & M_ISP) != 13'h0) ? m_sp + 8'd1 : m_sp - 8'd1;
                if (taken) begin
                    kept         = 13'h0;
                    m_flush_left = FLUSH_DEPTH - 1;
                    m_skip       = 1'b0;
                end else if (m_flush_left > 0) begin
                    kept = 13'h0;
                    m_flush_left--;
                end else if (m_skip) begin
                    kept   = 13'h0;
                    m_skip = 1'b0;
                end else begin
                    kept   = word;
                    m_skip = (word & M_BB2) != 13'h0;
                end
                void'(pipe.pop_back());
                pipe.push_front(kept);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [12:0] s3, s4;
        logic        req, stl, cm, pc;
        logic [15:0] e, a;
        if (model_ok) begin
            s3  = pipe[0];
            s4  = pipe[1];
            req = (s4 & (M_XWR | M_EIP)) != 13'h0;
            stl = req && !mem_ack;
            cm  = !stl;
            pc  = cm && ((s4 & M_LPC) != 13'h0) && flag_ok;
            e = {cm && ((s4 & M_XR0) != 13'h0), cm && ((s4 & M_XRN) != 13'h0),
                 req, (s4 & M_XWR) != 13'h0, pc, (s3 & M_FLR0) != 13'h0,
                 stl, pc || (m_flush_left > 0), m_sp};
            a = {WE_R0, WE_RN, MEM_REQ, MEM_WR, PC_LOAD, FWD_R0, STALL, FLUSH, SP};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model cycle %0d: {WE_R0,WE_RN,REQ,WR,PCL,FWD,STALL,FLUSH,SP} got %04h expected %04h",
                         cyc, a, e);
            end
        end
    end

    task automatic pin1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic pin8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then return at the negedge.
    task automatic tick(input logic [12:0] w, input logic ack, input logic fok, input logic r);
        @(posedge clk);
        #1;
        word    = w;
        mem_ack = ack;
        flag_ok = fok;
        rst     = r;
        @(negedge clk);
    endtask

    initial begin
        tick(13'h0, 1'b1, 1'b1, 1'b1);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin8("reset SP", SP, 8'hFF);
        pin1("reset MEM_REQ", MEM_REQ, 1'b0);
        pin1("reset FLUSH", FLUSH, 1'b0);
        pin1("reset STALL", STALL, 1'b0);

        // 1: MVI commits two edges after sampling, for one cycle.
        tick(W_MVI, 1'b1, 1'b1, 1'b0);
        pin1("t1 WE_RN early0", WE_RN, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t1 WE_RN early1", WE_RN, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t1 WE_RN commit", WE_RN, 1'b1);
        pin1("t1 WE_R0", WE_R0, 1'b0);
        pin8("t1 SP", SP, 8'hFF);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t1 WE_RN after", WE_RN, 1'b0);

        // 2: PSH stalls three cycles; following word held in S3.
        tick(W_PSH, 1'b0, 1'b1, 1'b0);
        tick(M_XR0 | M_FLR0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(13'h0, 1'b0, 1'b1, 1'b0);
            pin1("t2 STALL", STALL, 1'b1);
            pin1("t2 MEM_WR", MEM_WR, 1'b1);
            pin1("t2 FWD_R0 held", FWD_R0, 1'b1);
        end
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t2 ack STALL", STALL, 1'b0);
        pin1("t2 ack REQ", MEM_REQ, 1'b1);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin8("t2 SP push", SP, 8'hFE);
        pin1("t2 held word commits", WE_R0, 1'b1);
        tick(W_POP, 1'b1, 1'b1, 1'b0);
        tick(W_POP, 1'b1, 1'b1, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t2 POP REQ", MEM_REQ, 1'b1);
        pin1("t2 POP WR", MEM_WR, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin8("t2 SP pop1", SP, 8'hFF);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin8("t2 SP wrap", SP, 8'h00);

        // 3: taken jump skips its operand slot and squashes what follows.
        tick(W_JMP, 1'b1, 1'b1, 1'b0);
        tick(M_XR0, 1'b1, 1'b1, 1'b0);
        tick(M_XRN, 1'b1, 1'b1, 1'b0);
        pin1("t3 PC_LOAD", PC_LOAD, 1'b1);
        pin1("t3 FLUSH", FLUSH, 1'b1);
        tick(M_XR0, 1'b1, 1'b1, 1'b0);
        pin1("t3 PC_LOAD once", PC_LOAD, 1'b0);
        pin1("t3 FLUSH cnt", FLUSH, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(13'h0, 1'b1, 1'b1, 1'b0);
            pin1("t3 no WE_R0", WE_R0, 1'b0);
            pin1("t3 no WE_RN", WE_RN, 1'b0);
        end
        pin1("t3 FLUSH done", FLUSH, 1'b0);

        // 4: not-taken branch.
        tick(W_JMP, 1'b1, 1'b1, 1'b0);
        tick(M_XR0, 1'b1, 1'b1, 1'b0);
        tick(M_XRN, 1'b1, 1'b0, 1'b0);
        pin1("t4 no PC_LOAD", PC_LOAD, 1'b0);
        pin1("t4 no FLUSH", FLUSH, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t4 operand skipped", WE_R0, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t4 WE_RN", WE_RN, 1'b1);

        // 5: call: push, SP-1 and PC load in the ACK cycle, then flush.
        tick(W_CUD, 1'b0, 1'b1, 1'b0);
        tick(M_XR0, 1'b0, 1'b1, 1'b0);
        tick(M_XRN, 1'b0, 1'b1, 1'b0);
        pin1("t5 stall", STALL, 1'b1);
        pin1("t5 no early PC_LOAD", PC_LOAD, 1'b0);
        tick(M_XRN, 1'b0, 1'b1, 1'b0);
        tick(M_XRN, 1'b1, 1'b1, 1'b0);
        pin1("t5 PC_LOAD", PC_LOAD, 1'b1);
        pin1("t5 MEM_WR", MEM_WR, 1'b1);
        pin1("t5 FLUSH", FLUSH, 1'b1);
        pin8("t5 SP before", SP, 8'h00);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin8("t5 SP wrap", SP, 8'hFF);
        pin1("t5 FLUSH cnt", FLUSH, 1'b1);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin1("t5 FLUSH done", FLUSH, 1'b0);
        pin1("t5 squashed WE_RN", WE_RN, 1'b0);

        // 6: reset during a stalled PSH.
        tick(W_PSH, 1'b1, 1'b1, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        tick(13'h0, 1'b1, 1'b1, 1'b0);
        pin8("t6 SP pushed", SP, 8'hFE);
        tick(W_PSH, 1'b0, 1'b1, 1'b0);
        tick(13'h0, 1'b0, 1'b1, 1'b0);
        tick(13'h0, 1'b0, 1'b1, 1'b0);
        pin1("t6 stalled", STALL, 1'b1);
        tick(13'h0, 1'b0, 1'b1, 1'b1);
        tick(13'h0, 1'b0, 1'b1, 1'b0);
        pin1("t6 REQ cleared", MEM_REQ, 1'b0);
        pin1("t6 STALL cleared", STALL, 1'b0);
        pin8("t6 SP reset", SP, 8'hFF);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [12:0] w;
            w = 13'($urandom & $urandom);
            if ($urandom_range(0, 4) == 0) w = 13'h0;
            tick(w, $urandom_range(0, 9) < 6, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 399) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
